tx_mux_fifo_ctrl: RTL and testbench

- Parametrised successor of the single-channel TX FIFO controller, running entirely in the clk160 domain.
- Accepts N_CH independent 16-bit word streams, each buffered in its own synchronous FIFO.
- Drains the FIFOs through a round-robin arbiter into one registered output word stream, gated by tx_ready.
- Sits between the per-link frame builders and the transmitter serialiser input stage.

---
 rtl/tx_mux_pkg.sv | 29 ++
 rtl/tx_chan_fifo.sv | 83 ++++++++
 rtl/tx_mux_fifo_ctrl.sv | 176 +++++++++++++++++
 tb/tb_tx_mux_fifo_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_mux_pkg.sv
// ============================================================================
// Module      : tx_mux_pkg
// Description : Shared definitions for the multi-channel TX FIFO controller:
//               channel-index width helper, drop-counter constants and a
//               channel index type wide enough for the largest supported
//               channel count (16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_mux_pkg;

    // Per-channel drop counter geometry.
    localparam int          DROP_CNT_W   = 16;
    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    // Width of the channel index inside the arbiter (up to 16 channels).
    localparam int CH_IDX_W = 4;
    typedef logic [CH_IDX_W-1:0] chan_idx_t;

    // Width of a channel number on the output side; never narrower than
    // one bit so a single-channel build still has a legal port.
    function automatic int ch_w_calc(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_chan_fifo.sv
// ============================================================================
// Module      : tx_chan_fifo
// Description : Single-clock show-ahead FIFO. The head word is presented on
//               rd_data whenever the FIFO is non-empty; rd_en consumes it.
//               A write while full is accepted only when a read happens in
//               the same cycle.
// Ports       : clk160, rst (async, active-high)
//               wr_en / wr_data       - push side
//               rd_en / rd_data       - pop side (show-ahead head word)
//               empty, full, count    - status (full is registered)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_chan_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk160,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    C_FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_full;
    logic [AW:0]       w_count_nxt;
    logic              w_do_wr;
    logic              w_do_rd;

    assign w_do_rd = rd_en && (r_count != '0);
    // The push is gated again here so the FIFO can never corrupt itself,
    // even if the caller's acceptance logic is wrong.
    assign w_do_wr = wr_en && (!r_full || w_do_rd);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_wr, w_do_rd})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_FULL_CNT);
        end
    end

    // Storage needs no reset: nothing reads a slot before it is written.
    always_ff @(posedge clk160) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign empty   = (r_count == '0);
    assign full    = r_full;
    assign count   = r_count;

endmodule

`default_nettype wire

// File: rtl/tx_mux_fifo_ctrl.sv
// ============================================================================
// Module      : tx_mux_fifo_ctrl
// Description : N_CH independent word streams, each buffered in its own
//               show-ahead FIFO, drained by a round-robin arbiter into one
//               registered output stream gated by tx_ready. Dropped writes
//               set sticky per-channel overflow flags.
// Ports       : clk160, rst (async, active-high)
//               datain[N_CH*DATA_W], datain_valid[N_CH] - channel writes
//               tx_ready                 - downstream accepts a word
//               ovf_clr                  - clear overflow (and drop counters)
//               clr_valid[N_CH]          - pulse after an accepted write
//               fifo_full[N_CH]          - channel FIFO holds DEPTH words
//               overflow[N_CH]           - sticky write-dropped flags
//               dataout, dataout_valid, dataout_chan - output stream
//               drop_cnt[N_CH*16]        - only with TX_MUX_DROP_CNT_EN
// Build option: define TX_MUX_DROP_CNT_EN for saturating per-channel
//               16-bit drop counters on port drop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_mux_fifo_ctrl
    import tx_mux_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int N_CH   = 4
) (
    input  logic                          clk160,
    input  logic                          rst,
    input  logic [N_CH*DATA_W-1:0]        datain,
    input  logic [N_CH-1:0]               datain_valid,
    input  logic                          tx_ready,
    input  logic                          ovf_clr,
    output logic [N_CH-1:0]               clr_valid,
    output logic [N_CH-1:0]               fifo_full,
    output logic [N_CH-1:0]               overflow,
    output logic [DATA_W-1:0]             dataout,
    output logic                          dataout_valid,
    output logic [ch_w_calc(N_CH)-1:0]    dataout_chan
`ifdef TX_MUX_DROP_CNT_EN
    ,
    output logic [N_CH*DROP_CNT_W-1:0]    drop_cnt
`endif
);

    localparam int              CH_W      = ch_w_calc(N_CH);
    localparam int              CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   C_DEPTH   = CW'(DEPTH);
    localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(N_CH - 1);

    logic [DATA_W-1:0] w_rd_data [N_CH];
    logic [CW-1:0]     w_count   [N_CH];
    logic [N_CH-1:0]   w_empty;
    logic [N_CH-1:0]   w_rd_en;
    logic [N_CH-1:0]   w_wr_acc;
    logic [N_CH-1:0]   w_drop;
    logic [CH_W-1:0]   w_grant;
    logic              w_any;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;
    chan_idx_t         w_dist;
    chan_idx_t         w_best;
    logic [CH_W-1:0]   r_last_grant;

    // ------------------------------------------------------------------
    // Channel FIFOs and write acceptance
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_chan
            // A full channel still takes a write when it is being popped
            // in the same cycle.
            assign w_wr_acc[g] = datain_valid[g] &&
                                 ((w_count[g] != C_DEPTH) || w_rd_en[g]);
            assign w_drop[g]   = datain_valid[g] && !w_wr_acc[g];
            assign w_rd_en[g]  = w_pop && (w_grant == CH_W'(g));

            tx_chan_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk160  (clk160),
                .rst     (rst),
                .wr_en   (w_wr_acc[g]),
                .wr_data (datain[g*DATA_W +: DATA_W]),
                .rd_en   (w_rd_en[g]),
                .rd_data (w_rd_data[g]),
                .empty   (w_empty[g]),
                .full    (fifo_full[g]),
                .count   (w_count[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin arbiter: each non-empty channel is ranked by its
    // distance past the last grant; the smallest distance wins, which is
    // the first non-empty channel scanning upward from last_grant+1.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_best  = '1;
        w_dist  = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_dist = chan_idx_t'((c + N_CH - 1 - int'(r_last_grant)) % N_CH);
            if (!w_empty[c] && (!w_any || (w_dist < w_best))) begin
                w_any   = 1'b1;
                w_best  = w_dist;
                w_grant = CH_W'(c);
            end
        end
    end

    assign w_pop = tx_ready && w_any;

    always_comb begin
        w_head = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_grant == CH_W'(c)) w_head = w_rd_data[c];
        end
    end

    // ------------------------------------------------------------------
    // Output stage, overflow flags, write-accept pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            dataout       <= '0;
            dataout_chan  <= '0;
            dataout_valid <= 1'b0;
            r_last_grant  <= C_LAST_CH;
            clr_valid     <= '0;
            overflow      <= '0;
        end else begin
            clr_valid     <= w_wr_acc;
            // A drop in the clearing cycle keeps its flag set.
            overflow      <= (ovf_clr ? '0 : overflow) | w_drop;
            dataout_valid <= w_pop;
            if (w_pop) begin
                dataout      <= w_head;
                dataout_chan <= w_grant;
                r_last_grant <= w_grant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional saturating drop counters
    // ------------------------------------------------------------------
`ifdef TX_MUX_DROP_CNT_EN
    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_drop
            logic [DROP_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk160 or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_drop[g]) begin
                    if (ovf_clr)                   r_cnt <= DROP_CNT_W'(1);
                    else if (r_cnt != DROP_CNT_MAX) r_cnt <= r_cnt + 1'b1;
                end else if (ovf_clr) begin
                    r_cnt <= '0;
                end
            end

            assign drop_cnt[g*DROP_CNT_W +: DROP_CNT_W] = r_cnt;
        end
    endgenerate
`else
    // Drops are recorded by the sticky overflow flags alone in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_mux_fifo_ctrl.sv
// ============================================================================
// Module      : tb_tx_mux_fifo_ctrl
// Description : Self-checking bench for tx_mux_fifo_ctrl. A queue-based
//               reference model predicts every output after every edge;
//               directed scenarios are followed by a randomized phase.
//               Honours TX_MUX_DROP_CNT_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_mux_fifo_ctrl;
    import tx_mux_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int N_CH   = 4;
    localparam int CH_W   = ch_w_calc(N_CH);

    logic                     clk160 = 1'b0;
    logic                     rst;
    logic [N_CH*DATA_W-1:0]   datain;
    logic [N_CH-1:0]          datain_valid;
    logic                     tx_ready;
    logic                     ovf_clr;
    logic [N_CH-1:0]          clr_valid;
    logic [N_CH-1:0]          fifo_full;
    logic [N_CH-1:0]          overflow;
    logic [DATA_W-1:0]        dataout;
    logic                     dataout_valid;
    logic [CH_W-1:0]          dataout_chan;
`ifdef TX_MUX_DROP_CNT_EN
    logic [N_CH*16-1:0]       drop_cnt;
`endif

    tx_mux_fifo_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .N_CH   (N_CH)
    ) dut (
        .clk160        (clk160),
        .rst           (rst),
        .datain        (datain),
        .datain_valid  (datain_valid),
        .tx_ready      (tx_ready),
        .ovf_clr       (ovf_clr),
        .clr_valid     (clr_valid),
        .fifo_full     (fifo_full),
        .overflow      (overflow),
        .dataout       (dataout),
        .dataout_valid (dataout_valid),
        .dataout_chan  (dataout_chan)
`ifdef TX_MUX_DROP_CNT_EN
        ,
        .drop_cnt      (drop_cnt)
`endif
    );

    always #3 clk160 = ~clk160;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mq [N_CH][$];
    int                m_last;
    logic              e_dv;
    logic [DATA_W-1:0] e_dout;
    logic [CH_W-1:0]   e_chan;
    logic [N_CH-1:0]   e_clr;
    logic [N_CH-1:0]   e_ovf;
    logic [N_CH-1:0]   e_full;
    int                e_drop [N_CH];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            mq[c].delete();
            e_drop[c] = 0;
        end
        m_last = N_CH - 1;
        e_dv   = 1'b0;
        e_dout = '0;
        e_chan = '0;
        e_clr  = '0;
        e_ovf  = '0;
        e_full = '0;
    endtask

    // Predict the outputs after the next rising edge from the current inputs.
    task automatic model_step();
        logic            pop;
        int              g;
        logic [N_CH-1:0] drops;
        pop   = 1'b0;
        g     = 0;
        drops = '0;
        if (tx_ready) begin
            for (int i = 1; i <= N_CH; i++) begin
                int c;
                c = (m_last + i) % N_CH;
                if (!pop && mq[c].size() > 0) begin
                    pop = 1'b1;
                    g   = c;
                end
            end
        end
        e_dv = pop;
        if (pop) begin
            e_dout = mq[g].pop_front();
            e_chan = CH_W'(g);
            m_last = g;
        end
        e_clr = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (datain_valid[c]) begin
                if (mq[c].size() < DEPTH) begin
                    mq[c].push_back(datain[c*DATA_W +: DATA_W]);
                    e_clr[c] = 1'b1;
                end else begin
                    drops[c] = 1'b1;
                end
            end
        end
        e_ovf = (ovf_clr ? '0 : e_ovf) | drops;
        for (int c = 0; c < N_CH; c++) begin
            if (drops[c])     e_drop[c] = ovf_clr ? 1 : ((e_drop[c] < 65535) ? e_drop[c] + 1 : 65535);
            else if (ovf_clr) e_drop[c] = 0;
            e_full[c] = (mq[c].size() == DEPTH);
        end
    endtask

    task automatic compare_all();
        check("dataout_valid", 64'(dataout_valid), 64'(e_dv));
        check("dataout",       64'(dataout),       64'(e_dout));
        check("dataout_chan",  64'(dataout_chan),  64'(e_chan));
        check("clr_valid",     64'(clr_valid),     64'(e_clr));
        check("overflow",      64'(overflow),      64'(e_ovf));
        check("fifo_full",     64'(fifo_full),     64'(e_full));
`ifdef TX_MUX_DROP_CNT_EN
        for (int c = 0; c < N_CH; c++)
            check("drop_cnt", 64'(drop_cnt[c*16 +: 16]), 64'(16'(e_drop[c])));
`endif
    endtask

    // Inputs are set at a falling edge; step the model, clock, check.
    task automatic tick();
        model_step();
        @(posedge clk160);
        @(negedge clk160);
        cyc++;
        compare_all();
    endtask

    task automatic drain();
        datain_valid = '0;
        tx_ready     = 1'b1;
        ovf_clr      = 1'b1;
        tick();
        ovf_clr      = 1'b0;
        for (int k = 0; k < DEPTH*N_CH + 2; k++) tick();
    endtask

    task automatic do_reset();
        datain_valid = '0;
        tx_ready     = 1'b0;
        ovf_clr      = 1'b0;
        rst          = 1'b1;
        repeat (2) @(negedge clk160);
        rst = 1'b0;
        model_reset();
        compare_all();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int          nout;
        logic [15:0] last1;
        int          rp;

        datain       = '0;
        datain_valid = '0;
        tx_ready     = 1'b0;
        ovf_clr      = 1'b0;
        rst          = 1'b1;
        model_reset();
        repeat (2) @(negedge clk160);
        compare_all();
        rst = 1'b0;

        // Single write, latency and one-cycle valid
        datain          = '0;
        datain[15:0]    = 16'hA5A5;
        datain_valid    = 4'b0001;
        tx_ready        = 1'b1;
        tick();
        check("t1_clr_pulse", 64'(clr_valid[0]), 64'd1);
        check("t1_not_yet",   64'(dataout_valid), 64'd0);
        datain_valid = '0;
        tick();
        check("t1_valid", 64'(dataout_valid), 64'd1);
        check("t1_data",  64'(dataout),       64'hA5A5);
        check("t1_chan",  64'(dataout_chan),  64'd0);
        check("t1_clr_end", 64'(clr_valid[0]), 64'd0);
        tick();
        check("t1_one_cycle", 64'(dataout_valid), 64'd0);

        // Round robin over backlogged channels
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < N_CH; c++) datain[c*DATA_W +: DATA_W] = 16'(c*256 + k);
            datain_valid = '1;
            tick();
        end
        datain_valid = '0;
        tx_ready     = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("rr_valid", 64'(dataout_valid), 64'd1);
            check("rr_chan",  64'(dataout_chan),  64'(k % N_CH));
            check("rr_word",  64'(dataout),       64'(((k % N_CH) * 256) + k / N_CH));
        end
        tick();
        check("rr_done", 64'(dataout_valid), 64'd0);

        // Overflow on ch2
        tx_ready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            datain[2*DATA_W +: DATA_W] = 16'(16'h2000 + k);
            datain_valid = 4'b0100;
            tick();
            if (k == DEPTH - 1) begin
                check("ovf_full_at_depth", 64'(fifo_full[2]), 64'd1);
                check("ovf_not_yet",       64'(overflow[2]),  64'd0);
            end
        end
        check("ovf_set", 64'(overflow[2]), 64'd1);
`ifdef TX_MUX_DROP_CNT_EN
        check("ovf_drop_cnt", 64'(drop_cnt[2*16 +: 16]), 64'd2);
`endif
        datain_valid = '0;
        tx_ready     = 1'b1;
        nout         = 0;
        for (int k = 0; k < DEPTH + 3; k++) begin
            tick();
            if (dataout_valid) nout++;
        end
        check("ovf_drain_count", 64'(nout), 64'(DEPTH));
        drain();

        // Full channel popped and written in the same cycle
        tx_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            datain[1*DATA_W +: DATA_W] = 16'(16'h1000 + k);
            datain_valid = 4'b0010;
            tick();
        end
        check("fp_full", 64'(fifo_full[1]), 64'd1);
        datain[1*DATA_W +: DATA_W] = 16'h1234;
        datain_valid = 4'b0010;
        tx_ready     = 1'b1;
        tick();
        check("fp_no_ovf",  64'(overflow[1]),  64'd0);
        check("fp_accept",  64'(clr_valid[1]), 64'd1);
        datain_valid = '0;
        last1 = '0;
        nout  = 1;
        for (int k = 0; k < DEPTH + 3; k++) begin
            tick();
            if (dataout_valid && dataout_chan == CH_W'(1)) begin
                last1 = dataout;
                nout++;
            end
        end
        check("fp_last_word", 64'(last1), 64'h1234);
        check("fp_count",     64'(nout),  64'(DEPTH + 1));
        drain();

        // ovf_clr coinciding with a drop on ch3
        tx_ready = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) begin
            datain[0*DATA_W +: DATA_W] = 16'(16'h0C00 + k);
            datain[3*DATA_W +: DATA_W] = 16'(16'h3C00 + k);
            datain_valid = 4'b1001;
            tick();
        end
        check("oc_pre", 64'(overflow), 64'b1001);
        ovf_clr      = 1'b1;
        datain_valid = 4'b1000;
        tick();
        check("oc_set_wins", 64'(overflow), 64'b1000);
        ovf_clr = 1'b0;
        drain();

        // Reset in the middle of a drain
        tx_ready     = 1'b0;
        for (int c = 0; c < N_CH; c++) datain[c*DATA_W +: DATA_W] = 16'(16'h5000 + c);
        datain_valid = 4'b0111;
        tick();
        datain_valid = 4'b0011;
        tick();
        datain_valid = '0;
        tx_ready     = 1'b1;
        tick();
        check("rd_midrun_valid", 64'(dataout_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rd_valid_drop", 64'(dataout_valid), 64'd0);
        check("rd_full_clear", 64'(fifo_full),     64'd0);
        check("rd_dout_clear", 64'(dataout),       64'd0);
        @(negedge clk160);
        @(negedge clk160);
        rst = 1'b0;
        model_reset();
        compare_all();
        datain[0*DATA_W +: DATA_W] = 16'h0AAA;
        datain[1*DATA_W +: DATA_W] = 16'h1BBB;
        datain_valid = 4'b0011;
        tick();
        check("rd_no_stale", 64'(dataout_valid), 64'd0);
        datain_valid = '0;
        tick();
        check("rd_first_chan", 64'(dataout_chan), 64'd0);
        check("rd_first_word", 64'(dataout),      64'h0AAA);
        tick();
        check("rd_second_chan", 64'(dataout_chan), 64'd1);
        drain();

        // Randomized traffic with varying downstream back-pressure
        for (int n = 0; n < 3000; n++) begin
            case ((n / 300) % 3)
                0:       rp = 90;
                1:       rp = 50;
                default: rp = 10;
            endcase
            for (int c = 0; c < N_CH; c++) begin
                datain[c*DATA_W +: DATA_W] = 16'($urandom);
                datain_valid[c] = ($urandom_range(0, 99) < 35);
            end
            tx_ready = ($urandom_range(0, 99) < rp);
            ovf_clr  = ($urandom_range(0, 99) < 3);
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
